// File: rtl/mmio_responder.sv
// Memory-mapped responder: 32-byte register window with a down-counting timer/irq and a byte TX FIFO.
// Latency: rdata/sel registered, valid one cycle after addr; writes take effect on the hit edge.
// Backpressure: tx stream is valid/ready; a push into a full FIFO with no same-cycle pop is dropped and flags OVF.
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_TXDATA = 3'd1;
    localparam logic [2:0] OFF_LOAD   = 3'd2;
    localparam logic [2:0] OFF_COUNT  = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_CLR    = 3'd5;

    // Address decode; the two byte-lane bits carry no meaning for word registers.
    logic       hit;
    logic [2:0] offset;
    logic       unused_addr_bits;

    assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
    assign offset           = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];

    logic we_txdata, we_load, we_ctrl, we_clr;

    assign we_txdata = hit & wr & (offset == OFF_TXDATA);
    assign we_load   = hit & wr & (offset == OFF_LOAD);
    assign we_ctrl   = hit & wr & (offset == OFF_CTRL);
    assign we_clr    = hit & wr & (offset == OFF_CLR);

    // State
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   load_q, load_d;
    logic [31:0]   count_q, count_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          exp_q, exp_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          sel_q, sel_d;

    logic full, empty, pop, push_ok, drop, exp_set;
    logic [31:0] rd_val;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign pop     = ~empty & tx_ready;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_ok = we_txdata & (~full | pop);
    assign drop    = we_txdata & full & ~pop;

    // FIFO next state: storage, wrapping pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Timer next state; a LOAD write overrides any decrement or reload that edge.
    always_comb begin
        load_d  = we_load ? wdata : load_q;
        count_d = count_q;
        exp_set = 1'b0;
        if (we_load) begin
            count_d = wdata;
        end else if (ctrl_q[0]) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
                exp_set = (count_q == 32'd1);
            end else if (ctrl_q[1] && (load_q != 32'd0)) begin
                count_d = load_q;
            end
        end
    end

    // Sticky flags: a set on the same edge as its clear wins; irq follows EXP gated by irq_en.
    always_comb begin
        ctrl_d = we_ctrl ? wdata[2:0] : ctrl_q;
        exp_d  = exp_set | (exp_q & ~(we_clr & wdata[0]));
        ovf_d  = drop | (ovf_q & ~(we_clr & wdata[1]));
        irq_d  = exp_d & ctrl_d[2];
    end

    // Read mux from current register values; write-only and reserved slots read 0.
    always_comb begin
        rd_val = 32'd0;
        case (offset)
            OFF_STATUS: rd_val = {28'd0, ovf_q, exp_q, empty, full};
            OFF_LOAD:   rd_val = load_q;
            OFF_COUNT:  rd_val = count_q;
            OFF_CTRL:   rd_val = {29'd0, ctrl_q};
            default:    rd_val = 32'd0;
        endcase
        rdata_d = (hit & ~wr) ? rd_val : 32'd0;
        sel_d   = hit;
    end

    // All state registers, cleared asynchronously (FIFO contents included).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            load_q   <= 32'd0;
            count_q  <= 32'd0;
            ctrl_q   <= 3'd0;
            exp_q    <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
            sel_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            count_q  <= count_d;
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
        end
    end

    assign rdata    = rdata_q;
    assign sel      = sel_q;
    assign tx_data  = mem_q[rd_ptr_q];
    assign tx_valid = ~empty;
    assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed register/FIFO/timer scenarios then random bus traffic.
// Outputs are compared one time unit after each rising edge against a queue-based reference model.
// The tx sink readiness is randomised to exercise FIFO full/overflow and same-cycle push/pop.
module tb_mmio_responder;

    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  q[$];
    logic [31:0] m_load, m_count, m_rdata;
    logic [2:0]  m_ctrl;
    logic        m_exp, m_ovf, m_irq, m_sel;

    mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .sel      (sel),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_load  = 32'd0;
        m_count = 32'd0;
        m_rdata = 32'd0;
        m_ctrl  = 3'd0;
        m_exp   = 1'b0;
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        m_sel   = 1'b0;
    endtask

    // Advance the model by one bus cycle with the currently driven inputs, clock the DUT, compare.
    task automatic step();
        logic        h;
        logic [2:0]  o;
        logic [31:0] rv;
        logic        pop, push, drop, es, wclr;
        h  = ((addr >> 5) == (BASE >> 5));
        o  = addr[4:2];
        rv = 32'd0;
        case (o)
            3'd0: begin
                if (q.size() == DEPTH) rv = rv | 32'd1;
                if (q.size() == 0)     rv = rv | 32'd2;
                if (m_exp)             rv = rv | 32'd4;
                if (m_ovf)             rv = rv | 32'd8;
            end
            3'd2:    rv = m_load;
            3'd3:    rv = m_count;
            3'd4:    rv = {29'd0, m_ctrl};
            default: rv = 32'd0;
        endcase
        m_sel   = h;
        m_rdata = (h && !wr) ? rv : 32'd0;

        pop  = (q.size() > 0) && tx_ready;
        push = h && wr && (o == 3'd1);
        drop = push && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(wdata[7:0]);

        es = 1'b0;
        if (h && wr && (o == 3'd2)) begin
            m_load  = wdata;
            m_count = wdata;
        end else if (m_ctrl[0]) begin
            if (m_count != 0) begin
                es      = (m_count == 1);
                m_count = m_count - 1;
            end else if (m_ctrl[1] && (m_load != 0)) begin
                m_count = m_load;
            end
        end
        wclr  = h && wr && (o == 3'd5);
        m_exp = es || (m_exp && !(wclr && wdata[0]));
        m_ovf = drop || (m_ovf && !(wclr && wdata[1]));
        if (h && wr && (o == 3'd4)) m_ctrl = wdata[2:0];
        m_irq = m_exp && m_ctrl[2];

        @(posedge clk);
        #1;
        check("sel", {31'd0, sel}, {31'd0, m_sel});
        check("rdata", rdata, m_rdata);
        check("tx_valid", {31'd0, tx_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, q[0]});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d);
        addr  = a;
        wr    = w;
        wdata = d;
        step();
    endtask

    task automatic idle();
        cyc(32'h0000_0000, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  off;
        int          r;

        reset    = 1'b0;
        addr     = 32'd0;
        wr       = 1'b0;
        wdata    = 32'd0;
        tx_ready = 1'b0;
        model_reset();
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_sel", {31'd0, sel}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // STATUS after reset, then an out-of-window read.
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("status_empty", rdata, 32'h0000_0002);
        check("status_sel", {31'd0, sel}, 32'd1);
        cyc(32'h0000_0100, 1'b0, 32'd0);
        check("miss_sel", {31'd0, sel}, 32'd0);
        check("miss_rdata", rdata, 32'd0);

        // Fill, overflow, drain, clear OVF.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(BASE + 32'h04, 1'b1, 32'h41 + i);
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("status_full", rdata, 32'h0000_0001);
        cyc(BASE + 32'h04, 1'b1, 32'h45);
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("status_ovf", rdata, 32'h0000_0009);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_byte", {24'd0, tx_data}, 32'h41 + i);
            idle();
        end
        check("drain_done", {31'd0, tx_valid}, 32'd0);
        cyc(BASE + 32'h14, 1'b1, 32'd2);
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("status_clr_ovf", rdata, 32'h0000_0002);

        // Push into a full FIFO on the same edge as a pop.
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) cyc(BASE + 32'h04, 1'b1, i);
        tx_ready = 1'b1;
        cyc(BASE + 32'h04, 1'b1, 32'h55);
        check("fp_byte", {24'd0, tx_data}, 32'h02); idle();
        check("fp_byte", {24'd0, tx_data}, 32'h03); idle();
        check("fp_byte", {24'd0, tx_data}, 32'h04); idle();
        check("fp_byte5", {24'd0, tx_data}, 32'h55); idle();
        check("fp_done", {31'd0, tx_valid}, 32'd0);
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("fp_no_ovf", rdata, 32'h0000_0002);

        // One-shot timer with irq.
        cyc(BASE + 32'h08, 1'b1, 32'd3);
        cyc(BASE + 32'h10, 1'b1, 32'd5);
        idle();
        cyc(BASE + 32'h0C, 1'b0, 32'd0);
        check("os_count2", rdata, 32'd2);
        cyc(BASE + 32'h0C, 1'b0, 32'd0);
        check("os_count1", rdata, 32'd1);
        check("os_irq", {31'd0, irq}, 32'd1);
        cyc(BASE + 32'h0C, 1'b0, 32'd0);
        check("os_count0", rdata, 32'd0);
        cyc(BASE + 32'h0C, 1'b0, 32'd0);
        check("os_hold0", rdata, 32'd0);
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("os_status_exp", rdata, 32'h0000_0006);
        cyc(BASE + 32'h14, 1'b1, 32'd1);
        check("os_irq_clr", {31'd0, irq}, 32'd0);

        // Autoreload, and CLR colliding with a new expiry.
        cyc(BASE + 32'h10, 1'b1, 32'd0);
        cyc(BASE + 32'h08, 1'b1, 32'd2);
        cyc(BASE + 32'h10, 1'b1, 32'd7);
        idle();
        cyc(BASE + 32'h0C, 1'b0, 32'd0);
        check("ar_count1", rdata, 32'd1);
        cyc(BASE + 32'h14, 1'b1, 32'd1);
        cyc(BASE + 32'h0C, 1'b0, 32'd0);
        check("ar_reload", rdata, 32'd2);
        cyc(BASE + 32'h14, 1'b1, 32'd1);
        check("ar_irq_set_wins", {31'd0, irq}, 32'd1);
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("ar_exp_set_wins", rdata, 32'h0000_0006);

        // Asynchronous reset mid-transfer.
        cyc(BASE + 32'h10, 1'b1, 32'd0);
        tx_ready = 1'b0;
        cyc(BASE + 32'h04, 1'b1, 32'hA1);
        cyc(BASE + 32'h04, 1'b1, 32'hA2);
        cyc(BASE + 32'h08, 1'b1, 32'd3);
        cyc(BASE + 32'h10, 1'b1, 32'd7);
        repeat (4) idle();
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
        addr = BASE + 32'h0C;
        wr   = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("async_irq", {31'd0, irq}, 32'd0);
        check("async_sel", {31'd0, sel}, 32'd0);
        check("async_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc(BASE + 32'h0C, 1'b0, 32'd0);
        check("post_rst_count", rdata, 32'd0);
        cyc(BASE + 32'h00, 1'b0, 32'd0);
        check("post_rst_status", rdata, 32'h0000_0002);
        cyc(BASE + 32'h10, 1'b0, 32'd0);
        check("post_rst_ctrl", rdata, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 9);
            off = 3'($urandom_range(0, 7));
            if (r < 8)       a = BASE + {27'd0, off, 2'($urandom_range(0, 3))};
            else if (r == 8) a = $urandom;
            else             a = BASE ^ (32'h20 << $urandom_range(0, 26));
            d = $urandom;
            if (a[4:2] == 3'd2) d = $urandom_range(0, 8);
            tx_ready = ($urandom_range(0, 3) != 0);
            cyc(a, 1'($urandom_range(0, 1)), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
